// File: rtl/stream_programmer_if.sv
// Byte-in / word-out bus between a UART receiver, the stream programmer and a
// word-wide memory write port.
interface stream_programmer_if #(
    parameter int UART_DATA_LENGTH     = 8,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4
);
    logic                            active_i;
    logic [UART_DATA_LENGTH-1:0]     uart_data_i;
    logic                            data_valid_strb_i;
    logic [REGISTER_WIDTH-1:0]       data_o;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_o;
    logic                            enable_write_memory_o;
    logic                            busy_o;
    logic                            full_o;
    logic                            overflow_o;
    logic [MEMORY_ADDRESS_WIDTH:0]   word_count_o;

    modport master (
        output active_i, uart_data_i, data_valid_strb_i,
        input  data_o, addr_o, enable_write_memory_o, busy_o, full_o, overflow_o, word_count_o
    );

    modport slave (
        input  active_i, uart_data_i, data_valid_strb_i,
        output data_o, addr_o, enable_write_memory_o, busy_o, full_o, overflow_o, word_count_o
    );
endinterface

// File: rtl/stream_programmer.sv
// Splits each received byte into K memory words (most-significant first) and
// writes them to consecutive addresses, one word per cycle.
//
// state | meaning
// IDLE  | waiting for a byte strobe
// WRITE | emitting the words of the captured byte
// FULL  | last address written (no wrap); further bytes are dropped
module stream_programmer #(
    parameter int UART_DATA_LENGTH     = 8,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter bit WRAP_EN              = 1'b0
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    stream_programmer_if.slave  bus
);
    localparam int K     = UART_DATA_LENGTH / REGISTER_WIDTH;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [IDX_W-1:0]              LAST_IDX  = IDX_W'(K - 1);
    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [MEMORY_ADDRESS_WIDTH:0]   COUNT_MAX = {1'b1, {MEMORY_ADDRESS_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [UART_DATA_LENGTH-1:0]     byte_q, byte_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [MEMORY_ADDRESS_WIDTH:0]   count_q, count_d;
    logic                            full_q, full_d;
    logic                            ovf_q, ovf_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        count_d = count_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        if (!bus.active_i) begin
            state_d = IDLE;
            idx_d   = '0;
            addr_d  = '0;
            count_d = '0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.data_valid_strb_i) begin
                        byte_d  = bus.uart_data_i;
                        idx_d   = '0;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    addr_d = addr_q + 1'b1;
                    if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
                    // Filling the last address ends the byte even mid-way through it
                    if (!WRAP_EN && addr_q == ADDR_MAX) begin
                        state_d = FULL;
                        full_d  = 1'b1;
                        idx_d   = '0;
                        if (bus.data_valid_strb_i) ovf_d = 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        if (bus.data_valid_strb_i) begin
                            byte_d = bus.uart_data_i;
                            idx_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (bus.data_valid_strb_i) ovf_d = 1'b1;
                    end
                end
                FULL: begin
                    if (bus.data_valid_strb_i) ovf_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.enable_write_memory_o = 1'b0;
        bus.data_o                = '0;
        bus.addr_o                = '0;
        bus.busy_o                = 1'b0;
        if (state_q == WRITE) begin
            bus.busy_o                = 1'b1;
            bus.enable_write_memory_o = bus.active_i;
            bus.addr_o                = addr_q;
            bus.data_o = REGISTER_WIDTH'(byte_q >> (REGISTER_WIDTH * (K - 1 - int'(idx_q))));
        end
        bus.full_o       = full_q;
        bus.overflow_o   = ovf_q;
        bus.word_count_o = count_q;
    end
endmodule

// File: tb/tb_stream_programmer.sv
// Drives two programmers (no-wrap and wrap) with the same byte stream and
// checks them against a word-queue model plus hand-computed expectations.
module tb_stream_programmer;
    localparam int UDL = 8;
    localparam int RW  = 4;
    localparam int MAW = 4;
    localparam int K   = UDL / RW;
    localparam int D   = 1 << MAW;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    stream_programmer_if #(.UART_DATA_LENGTH(UDL), .REGISTER_WIDTH(RW), .MEMORY_ADDRESS_WIDTH(MAW)) b0 ();
    stream_programmer_if #(.UART_DATA_LENGTH(UDL), .REGISTER_WIDTH(RW), .MEMORY_ADDRESS_WIDTH(MAW)) b1 ();

    stream_programmer #(.UART_DATA_LENGTH(UDL), .REGISTER_WIDTH(RW),
                        .MEMORY_ADDRESS_WIDTH(MAW), .WRAP_EN(1'b0))
        dut0 (.clk_i(clk), .reset_ni(rst_n), .bus(b0));
    stream_programmer #(.UART_DATA_LENGTH(UDL), .REGISTER_WIDTH(RW),
                        .MEMORY_ADDRESS_WIDTH(MAW), .WRAP_EN(1'b1))
        dut1 (.clk_i(clk), .reset_ni(rst_n), .bus(b1));

    always #5 clk = ~clk;

    // Model: bytes become a run of pending words; m_left counts words still to go.
    int       m_left [2];
    int       m_addr [2];
    int       m_cnt  [2];
    bit       m_full [2];
    bit       m_ovf  [2];
    logic [7:0] m_byte [2];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear(int i);
        m_left[i] = 0; m_addr[i] = 0; m_cnt[i] = 0; m_full[i] = 0; m_ovf[i] = 0;
    endfunction

    function automatic void model_step(int i, bit wrap, bit act, bit strb, logic [7:0] d);
        if (!act) begin
            model_clear(i);
            return;
        end
        if (m_left[i] > 0) begin
            m_left[i]--;
            if (m_cnt[i] < D) m_cnt[i]++;
            if (!wrap && m_addr[i] == D - 1) begin
                m_full[i] = 1;
                m_left[i] = 0;
            end
            m_addr[i] = (m_addr[i] + 1) % D;
        end
        if (strb) begin
            if (m_left[i] == 0 && !m_full[i]) begin
                m_byte[i] = d;
                m_left[i] = K;
            end else begin
                m_ovf[i] = 1;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear(0);
            model_clear(1);
            m_byte[0] = '0;
            m_byte[1] = '0;
        end else begin
            model_step(0, 1'b0, b0.active_i, b0.data_valid_strb_i, b0.uart_data_i);
            model_step(1, 1'b1, b1.active_i, b1.data_valid_strb_i, b1.uart_data_i);
        end
    end

    task automatic compare(int i, logic act, logic we, logic [3:0] addr, logic [3:0] data,
                           logic busy, logic full, logic ovf, logic [4:0] cnt);
        bit   w   = m_left[i] > 0;
        logic [7:0] sh = w ? (m_byte[i] >> ((m_left[i] - 1) * RW)) : 8'h00;
        string p  = (i == 0) ? "dut0" : "dut1";
        check({p, ".we"},    32'(we),   32'(w && act));
        check({p, ".addr"},  32'(addr), w ? 32'(m_addr[i]) : 32'd0);
        check({p, ".data"},  32'(data), 32'(sh[3:0]));
        check({p, ".busy"},  32'(busy), 32'(w));
        check({p, ".full"},  32'(full), 32'(m_full[i]));
        check({p, ".ovf"},   32'(ovf),  32'(m_ovf[i]));
        check({p, ".count"}, 32'(cnt),  32'(m_cnt[i]));
    endtask

    always @(negedge clk) begin
        compare(0, b0.active_i, b0.enable_write_memory_o, b0.addr_o, b0.data_o, b0.busy_o,
                b0.full_o, b0.overflow_o, b0.word_count_o);
        compare(1, b1.active_i, b1.enable_write_memory_o, b1.addr_o, b1.data_o, b1.busy_o,
                b1.full_o, b1.overflow_o, b1.word_count_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(bit s, logic [7:0] d);
        b0.data_valid_strb_i = s; b1.data_valid_strb_i = s;
        b0.uart_data_i = d;       b1.uart_data_i = d;
    endtask

    task automatic set_act(bit a);
        b0.active_i = a; b1.active_i = a;
    endtask

    task automatic lit_write(string name, logic [3:0] a, logic [3:0] d);
        check({name, ".we"},   32'(b0.enable_write_memory_o), 32'd1);
        check({name, ".addr"}, 32'(b0.addr_o), 32'(a));
        check({name, ".data"}, 32'(b0.data_o), 32'(d));
    endtask

    initial begin
        rst_n = 1'b1;
        set_act(1'b0);
        drv(1'b0, 8'h00);
        #1 rst_n = 1'b0;
        #2;
        check("rst.we",    32'(b0.enable_write_memory_o), 32'd0);
        check("rst.busy",  32'(b0.busy_o), 32'd0);
        check("rst.count", 32'(b0.word_count_o), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        set_act(1'b1);
        tick();

        // single byte 0xA5; live data changes after the strobe
        drv(1'b1, 8'hA5); tick();
        drv(1'b0, 8'h00);
        lit_write("single0", 4'h0, 4'hA);
        check("single0.busy", 32'(b0.busy_o), 32'd1);
        tick();
        lit_write("single1", 4'h1, 4'h5);
        tick();
        check("single.idle_we", 32'(b0.enable_write_memory_o), 32'd0);
        check("single.count", 32'(b0.word_count_o), 32'd2);

        set_act(1'b0); tick(); set_act(1'b1); tick();

        // back-to-back: second byte lands on the last word of the first
        drv(1'b1, 8'h3C); tick();
        drv(1'b0, 8'h00);
        lit_write("b2b0", 4'h0, 4'h3);
        tick();
        lit_write("b2b1", 4'h1, 4'hC);
        drv(1'b1, 8'h71); tick();
        drv(1'b0, 8'h00);
        lit_write("b2b2", 4'h2, 4'h7);
        tick();
        lit_write("b2b3", 4'h3, 4'h1);
        tick();
        check("b2b.ovf", 32'(b0.overflow_o), 32'd0);
        check("b2b.count", 32'(b0.word_count_o), 32'd4);

        set_act(1'b0); tick(); set_act(1'b1); tick();

        // drop: strobe during first word
        drv(1'b1, 8'hAA); tick();
        drv(1'b1, 8'h55); tick();
        drv(1'b0, 8'h00);
        lit_write("drop1", 4'h1, 4'hA);
        tick();
        check("drop.ovf", 32'(b0.overflow_o), 32'd1);
        check("drop.count", 32'(b0.word_count_o), 32'd2);
        repeat (3) tick();
        check("drop.ovf_sticky", 32'(b0.overflow_o), 32'd1);
        set_act(1'b0); tick();
        check("drop.ovf_clr", 32'(b0.overflow_o), 32'd0);
        set_act(1'b1); tick();

        // fill: 8 bytes then a ninth
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, {4'(i), 4'(15 - i)}); tick();
            drv(1'b0, 8'h00); tick(); tick();
        end
        check("fill.full0", 32'(b0.full_o), 32'd1);
        check("fill.count0", 32'(b0.word_count_o), 32'd16);
        check("fill.full1", 32'(b1.full_o), 32'd0);
        drv(1'b1, 8'h9E); tick();
        drv(1'b0, 8'h00);
        check("ninth.we0", 32'(b0.enable_write_memory_o), 32'd0);
        check("ninth.w1a", 32'(b1.addr_o), 32'd0);
        check("ninth.w1d", 32'(b1.data_o), 32'h9);
        tick();
        check("ninth.w1a2", 32'(b1.addr_o), 32'd1);
        check("ninth.w1d2", 32'(b1.data_o), 32'hE);
        tick();
        check("ninth.ovf0", 32'(b0.overflow_o), 32'd1);
        check("ninth.ovf1", 32'(b1.overflow_o), 32'd0);
        check("ninth.count1", 32'(b1.word_count_o), 32'd16);

        set_act(1'b0); tick(); set_act(1'b1); tick();

        // abort: active drops in the first write cycle
        drv(1'b1, 8'h5A); tick();
        drv(1'b0, 8'h00);
        set_act(1'b0);
        #1 check("abort.we", 32'(b0.enable_write_memory_o), 32'd0);
        tick();
        set_act(1'b1);
        check("abort.busy", 32'(b0.busy_o), 32'd0);
        drv(1'b1, 8'hC3); tick();
        drv(1'b0, 8'h00);
        lit_write("abort.next0", 4'h0, 4'hC);
        tick();
        lit_write("abort.next1", 4'h1, 4'h3);
        tick();

        // inactive strobe is ignored without overflow
        set_act(1'b0);
        drv(1'b1, 8'hFF); tick();
        drv(1'b0, 8'h00);
        check("inact.ovf", 32'(b0.overflow_o), 32'd0);
        check("inact.we", 32'(b0.enable_write_memory_o), 32'd0);
        set_act(1'b1); tick();

        // async reset mid-write
        drv(1'b1, 8'h96); tick();
        drv(1'b0, 8'h00);
        lit_write("areset.pre", 4'h0, 4'h9);
        #2 rst_n = 1'b0;
        #1;
        check("areset.we",   32'(b0.enable_write_memory_o), 32'd0);
        check("areset.busy", 32'(b0.busy_o), 32'd0);
        check("areset.data", 32'(b0.data_o), 32'd0);
        check("areset.count", 32'(b0.word_count_o), 32'd0);
        #2 rst_n = 1'b1;
        tick(); tick();
        check("areset.idle", 32'(b0.busy_o), 32'd0);
        drv(1'b1, 8'h81); tick();
        drv(1'b0, 8'h00);
        lit_write("areset.next", 4'h0, 4'h8);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_programmer.md
STREAM_PROGRAMMER -- requirements
Module: stream_programmer

Interface
REQ-001 Parameter UART_DATA_LENGTH, default 8: received byte width.
REQ-002 Parameter REGISTER_WIDTH, default 4: memory word width; SHALL divide UART_DATA_LENGTH evenly, with K = UART_DATA_LENGTH/REGISTER_WIDTH words per byte.
REQ-003 Parameter MEMORY_ADDRESS_WIDTH, default 4: memory address width; depth D = 2^MEMORY_ADDRESS_WIDTH.
REQ-004 Parameter WRAP_EN, default 0: 1 = address wraps to 0 after D-1; 0 = stop when full.
REQ-005 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_ni  input  1  reset, asynchronous, active-low.
REQ-007 active_i  input  1  programming mode enable; low holds the block cleared.
REQ-008 uart_data_i  input  UART_DATA_LENGTH  received byte, valid only with the strobe.
REQ-009 data_valid_strb_i  input  1  one-cycle byte-valid strobe.
REQ-010 data_o  output  REGISTER_WIDTH  word to write.
REQ-011 addr_o  output  MEMORY_ADDRESS_WIDTH  write address.
REQ-012 enable_write_memory_o  output  1  memory write enable, one cycle per word.
REQ-013 busy_o  output  1  high while the words of a byte are being emitted.
REQ-014 full_o  output  1  sticky; memory filled (WRAP_EN=0 only).
REQ-015 overflow_o  output  1  sticky; a byte was dropped.
REQ-016 word_count_o  output  MEMORY_ADDRESS_WIDTH+1  words written since activation, saturating at D.

Function
REQ-017 States SHALL be IDLE, WRITE and FULL, plus a word index 0..K-1, a captured-byte register and an address counter.
REQ-018 IDLE: a strobe with active_i=1 SHALL capture uart_data_i, set word index 0 and enter WRITE on the next cycle.
REQ-019 WRITE: each cycle SHALL drive enable_write_memory_o=1, addr_o=address counter and data_o=captured word at the word index (most-significant word first); address and index then increment.
REQ-020 Latency: strobe in cycle N -> writes in cycles N+1..N+K; busy_o high in exactly those cycles.
REQ-021 data_o SHALL come only from the captured register, never from live uart_data_i.
REQ-022 Outside WRITE, enable_write_memory_o, data_o and addr_o SHALL all be 0.
REQ-023 A strobe coincident with the last word (index K-1) SHALL be accepted: capture it, index to 0, stay in WRITE, with no idle gap.
REQ-024 A strobe during any other WRITE cycle, or in FULL, SHALL be dropped and set overflow_o.
REQ-025 After writing address D-1 with WRAP_EN=0: on the last word, go to FULL and set full_o; on a mid-byte word, discard the remaining words, go to FULL and set full_o.
REQ-026 With WRAP_EN=1, the address SHALL wrap from D-1 to 0 and the block never enters FULL.
REQ-027 word_count_o SHALL increment per write enable and saturate at D.
REQ-028 active_i=0 in any cycle SHALL, in that cycle, force enable_write_memory_o=0.
REQ-029 active_i=0 SHALL, at the next edge, return to IDLE and clear the address, word index, word_count_o, full_o and overflow_o.
REQ-030 A strobe with active_i=0 SHALL be ignored, and SHALL NOT set overflow_o.
REQ-031 Address and counter arithmetic SHALL be unsigned modulo their declared widths.

Reset
REQ-032 reset_ni low SHALL immediately force IDLE and set to 0: address, index, captured byte, word_count_o, full_o, overflow_o, busy_o and all write outputs.
REQ-033 Reset asserted mid-WRITE SHALL abort the byte with no further write enables; after release, the block waits in IDLE for a new strobe.

Verification (defaults, WRAP_EN=0 unless stated)
REQ-034 Single byte: active, strobe 0xA5 -> cycle N+1: addr 0, data 0xA; cycle N+2: addr 1, data 0x5; then IDLE with word_count_o=2.
REQ-035 Back-to-back: strobe 0x3C, then 0x71 coincident with its second write -> four consecutive writes (0,3)(1,C)(2,7)(3,1), overflow_o=0.
REQ-036 Drop: second strobe during the first write cycle -> that byte is not written and overflow_o=1 until active_i falls.
REQ-037 Full: 8 bytes -> addresses 0..15 written, full_o=1, word_count_o=16; a ninth strobe -> no write and overflow_o=1. Same test with WRAP_EN=1 -> ninth byte written at addresses 0 and 1, full_o=0.
REQ-038 Abort: active_i low in the cycle after the strobe -> no write enable in that cycle, then IDLE with address 0; the next byte writes at address 0.
REQ-039 Async reset: reset_ni low mid-WRITE, between clock edges -> outputs go to 0 without waiting for a clock edge.
